// File: rtl/ch_config_frame_decoder_if.sv
// Host command byte stream in, channel configuration write bus out.
// Master is the byte source / register side; slave is the frame decoder.
interface ch_config_frame_decoder_if #(
    parameter int NUM_CH = 2
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [NUM_CH-1:0] CH_CONFIG_WE;
    logic [7:0]        CH_CONFIG_ADDR;
    logic [7:0]        CH_CONFIG_DATA;

    modport master (
        output rx_valid,
        output rx_data,
        input  CH_CONFIG_WE,
        input  CH_CONFIG_ADDR,
        input  CH_CONFIG_DATA
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output CH_CONFIG_WE,
        output CH_CONFIG_ADDR,
        output CH_CONFIG_DATA
    );
endinterface

// File: rtl/ch_config_frame_decoder.sv
// Reassembles SYNC/CH/ADDR/DATA/CHK frames into per-channel register writes,
// rejecting bad checksums, bad channels and stalled frames.
module ch_config_frame_decoder #(
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic                            CLK_LOW,
    input  logic                            reset_n,
    ch_config_frame_decoder_if.slave        bus,
    output logic                            busy,
    output logic                            frame_err,
    output logic [1:0]                      err_code,
    output logic [7:0]                      err_cnt
);

    localparam logic [7:0] SYNC  = 8'hA5;
    localparam logic [7:0] BCAST = 8'hFF;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_CH,
        GET_ADDR,
        GET_DATA,
        GET_CHK
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [TW-1:0]     timer;
    logic [7:0]        ch_q;
    logic [7:0]        addr_q;
    logic [7:0]        data_q;
    logic [NUM_CH-1:0] we_q;
    logic [NUM_CH-1:0] we_d;
    logic [7:0]        addr_o;
    logic [7:0]        data_o;
    logic              timeout;
    logic              chk_ok;
    logic              ch_ok;
    logic              bcast;
    logic              commit;
    logic              err;
    logic [1:0]        code;

    assign bus.CH_CONFIG_WE   = we_q;
    assign bus.CH_CONFIG_ADDR = addr_o;
    assign bus.CH_CONFIG_DATA = data_o;

    // A byte arriving in the last allowed cycle keeps the frame alive.
    assign timeout = (state != IDLE) && !bus.rx_valid && (timer == T_LAST);
    assign chk_ok  = (bus.rx_data == (ch_q ^ addr_q ^ data_q));
    assign bcast   = (ch_q == BCAST);
    assign ch_ok   = bcast || (ch_q < 8'(NUM_CH));

    always_comb begin
        we_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            we_d[i] = bcast || (ch_q == 8'(i));
        end
    end

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        err     = 1'b0;
        code    = 2'b00;
        if (timeout) begin
            state_n = IDLE;
            err     = 1'b1;
            code    = 2'b11;
        end else if (bus.rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (bus.rx_data == SYNC) begin
                        state_n = GET_CH;
                    end
                end
                GET_CH:   state_n = GET_ADDR;
                GET_ADDR: state_n = GET_DATA;
                GET_DATA: state_n = GET_CHK;
                GET_CHK: begin
                    state_n = IDLE;
                    if (!chk_ok) begin
                        err  = 1'b1;
                        code = 2'b01;
                    end else if (!ch_ok) begin
                        err  = 1'b1;
                        code = 2'b10;
                    end else begin
                        commit = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            if (state == IDLE || bus.rx_valid || timeout) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            ch_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else if (bus.rx_valid) begin
            if (state == GET_CH) begin
                ch_q <= bus.rx_data;
            end
            if (state == GET_ADDR) begin
                addr_q <= bus.rx_data;
            end
            if (state == GET_DATA) begin
                data_q <= bus.rx_data;
            end
        end
    end

    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            we_q      <= '0;
            addr_o    <= '0;
            data_o    <= '0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            err_cnt   <= '0;
        end else begin
            we_q      <= commit ? we_d : '0;
            frame_err <= err;
            if (commit) begin
                addr_o <= addr_q;
                data_o <= data_q;
            end
            if (err) begin
                err_code <= code;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ch_config_frame_decoder.sv
// Directed bench for the channel configuration frame decoder.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ch_config_frame_decoder;

    localparam int NCH = 2;
    localparam int TO  = 20;

    logic       CLK_LOW = 1'b0;
    logic       reset_n;
    logic       busy;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;
    int         checks = 0;
    int         errors = 0;

    ch_config_frame_decoder_if #(.NUM_CH(NCH)) bus ();

    ch_config_frame_decoder #(
        .NUM_CH(NCH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK_LOW(CLK_LOW),
        .reset_n(reset_n),
        .bus(bus),
        .busy(busy),
        .frame_err(frame_err),
        .err_code(err_code),
        .err_cnt(err_cnt)
    );

    always #5 CLK_LOW = ~CLK_LOW;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge CLK_LOW);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
    endtask

    task automatic stop();
        @(negedge CLK_LOW);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] k);
        drive(8'hA5);
        drive(c);
        drive(a);
        drive(d);
        drive(k);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, 32'(bus.CH_CONFIG_WE), 32'h0);
        check({tag, "_addr"}, 32'(bus.CH_CONFIG_ADDR), 32'h0);
        check({tag, "_data"}, 32'(bus.CH_CONFIG_DATA), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_ferr"}, 32'(frame_err), 32'h0);
        check({tag, "_code"}, 32'(err_code), 32'h0);
        check({tag, "_cnt"}, 32'(err_cnt), 32'h0);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #2;
        check_reset_vals("rst");
        @(negedge CLK_LOW);
        reset_n = 1'b1;

        // good unicast frame
        drive(8'hA5);
        drive(8'h00);
        check("busy_mid", 32'(busy), 32'h1);
        drive(8'h2D);
        drive(8'h01);
        drive(8'h2C);
        stop();
        check("uni_we", 32'(bus.CH_CONFIG_WE), 32'h1);
        check("uni_addr", 32'(bus.CH_CONFIG_ADDR), 32'h2D);
        check("uni_data", 32'(bus.CH_CONFIG_DATA), 32'h01);
        check("uni_ferr", 32'(frame_err), 32'h0);
        check("uni_busy", 32'(busy), 32'h0);
        stop();
        check("uni_we_1cyc", 32'(bus.CH_CONFIG_WE), 32'h0);

        // broadcast, back-to-back
        frame(8'hFF, 8'h31, 8'h05, 8'hCB);
        drive(8'hA5);
        check("bc1_we", 32'(bus.CH_CONFIG_WE), 32'h3);
        check("bc1_addr", 32'(bus.CH_CONFIG_ADDR), 32'h31);
        check("bc1_data", 32'(bus.CH_CONFIG_DATA), 32'h05);
        drive(8'hFF);
        check("bc_gap_we", 32'(bus.CH_CONFIG_WE), 32'h0);
        drive(8'h31);
        drive(8'h05);
        drive(8'hCB);
        stop();
        check("bc2_we", 32'(bus.CH_CONFIG_WE), 32'h3);

        // bad checksum
        frame(8'h00, 8'h05, 8'h10, 8'h00);
        stop();
        check("chk_ferr", 32'(frame_err), 32'h1);
        check("chk_code", 32'(err_code), 32'h1);
        check("chk_cnt", 32'(err_cnt), 32'h1);
        check("chk_we", 32'(bus.CH_CONFIG_WE), 32'h0);
        check("chk_addr", 32'(bus.CH_CONFIG_ADDR), 32'h31);
        check("chk_data", 32'(bus.CH_CONFIG_DATA), 32'h05);
        stop();
        check("chk_ferr_1cyc", 32'(frame_err), 32'h0);

        // bad channel, correct checksum
        frame(8'h02, 8'h01, 8'h7F, 8'h7C);
        stop();
        check("ch_ferr", 32'(frame_err), 32'h1);
        check("ch_code", 32'(err_code), 32'h2);
        check("ch_cnt", 32'(err_cnt), 32'h2);
        check("ch_we", 32'(bus.CH_CONFIG_WE), 32'h0);

        // stall after CH byte
        drive(8'hA5);
        drive(8'h00);
        stop();
        repeat (TO - 1) @(negedge CLK_LOW);
        check("to_early_ferr", 32'(frame_err), 32'h0);
        check("to_early_busy", 32'(busy), 32'h1);
        @(negedge CLK_LOW);
        check("to_ferr", 32'(frame_err), 32'h1);
        check("to_code", 32'(err_code), 32'h3);
        check("to_busy", 32'(busy), 32'h0);
        check("to_cnt", 32'(err_cnt), 32'h3);
        check("to_we", 32'(bus.CH_CONFIG_WE), 32'h0);

        frame(8'h01, 8'h2D, 8'h01, 8'h2D);
        stop();
        check("after_to_we", 32'(bus.CH_CONFIG_WE), 32'h2);
        check("after_to_ferr", 32'(frame_err), 32'h0);

        // byte arrives in the timeout cycle
        drive(8'hA5);
        drive(8'h00);
        stop();
        repeat (TO - 2) @(negedge CLK_LOW);
        drive(8'h2D);
        check("edge_busy", 32'(busy), 32'h1);
        drive(8'h01);
        check("edge_ferr", 32'(frame_err), 32'h0);
        drive(8'h2C);
        stop();
        check("edge_we", 32'(bus.CH_CONFIG_WE), 32'h1);
        check("edge_cnt", 32'(err_cnt), 32'h3);

        // garbage before SYNC
        drive(8'h12);
        drive(8'h34);
        frame(8'h00, 8'h2D, 8'h01, 8'h2C);
        stop();
        check("garb_we", 32'(bus.CH_CONFIG_WE), 32'h1);
        check("garb_ferr", 32'(frame_err), 32'h0);
        check("garb_cnt", 32'(err_cnt), 32'h3);
        stop();
        check("garb_we_once", 32'(bus.CH_CONFIG_WE), 32'h0);

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            frame(8'h00, 8'h05, 8'h10, 8'h00);
        end
        stop();
        check("sat_cnt", 32'(err_cnt), 32'hFF);
        check("sat_ferr", 32'(frame_err), 32'h1);
        check("sat_code", 32'(err_code), 32'h1);

        // reset mid-frame
        drive(8'hA5);
        drive(8'h00);
        drive(8'h2D);
        stop();
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge CLK_LOW);
        reset_n = 1'b1;
        frame(8'h01, 8'h2D, 8'h01, 8'h2D);
        stop();
        check("post_rst_we", 32'(bus.CH_CONFIG_WE), 32'h2);
        check("post_rst_addr", 32'(bus.CH_CONFIG_ADDR), 32'h2D);
        check("post_rst_data", 32'(bus.CH_CONFIG_DATA), 32'h01);
        check("post_rst_cnt", 32'(err_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ch_config_frame_decoder.md
# ch_config_frame_decoder

Turns the host command byte stream from the serial receiver into per-channel register-write strobes for the channel configuration registers. It sits directly upstream of the per-channel configuration register blocks. It reassembles 5-byte frames and validates each frame's checksum and channel field. For every good frame it drives exactly one single-cycle write (address/data bus plus a per-channel write-enable). It also discards stray bytes, recovers from stalled frames by timeout, and counts errors.

## Interface
- NUM_CH, 2: number of channels; valid range 1..8.
- TIMEOUT_CYCLES, 25000: number of idle CLK_LOW cycles allowed mid-frame before the frame is abandoned; must be ≥2.
- CLK_LOW  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  single-cycle strobe; rx_data is valid in that cycle. Bytes may arrive every cycle.
- rx_data  in  8  received byte.
- CH_CONFIG_WE  out  NUM_CH  one-hot or all-ones write strobe, one cycle wide.
- CH_CONFIG_ADDR  out  8  register address; held until the next good frame.
- CH_CONFIG_DATA  out  8  register data; held until the next good frame.
- busy  out  1  high whenever state ≠ IDLE.
- frame_err  out  1  one-cycle pulse per rejected frame.
- err_code  out  2  code of the last error: 01 checksum, 10 bad channel, 11 timeout. Holds its value until the next error.
- err_cnt  out  8  rejected-frame count, saturating at 255.

## Operation
- Frame format, in byte order: SYNC = 0xA5, CH, ADDR, DATA, CHK.
- Checksum rule: CHK must equal CH ^ ADDR ^ DATA.
- CH field: values 0..NUM_CH-1 select that single channel. 0xFF is broadcast. Any other value is a bad channel.
- FSM states: IDLE → GET_CH → GET_ADDR → GET_DATA → GET_CHK → IDLE. The FSM advances only on rx_valid.
- IDLE: a byte equal to 0xA5 moves the FSM to GET_CH. Any other byte is dropped silently, with no error and no count.
- GET_CH, GET_ADDR, GET_DATA: each latches its byte into an internal register. A 0xA5 byte is treated as data here, not as a resync.
- GET_CHK, on receiving the CHK byte, checks in priority order:
  - Checksum mismatch: error 01.
  - Otherwise a bad channel: error 10.
  - Otherwise the frame is good: commit the write.
  - In every case the FSM returns to IDLE.
- Commit:
  - CH_CONFIG_ADDR and CH_CONFIG_DATA load the latched values.
  - CH_CONFIG_WE gets bit CH set, or all NUM_CH bits set for broadcast.
- Error:
  - frame_err pulses.
  - err_code loads the code.
  - err_cnt increments unless already 255.
  - No WE bit is asserted.
  - CH_CONFIG_ADDR and CH_CONFIG_DATA are left unchanged.
- Timeout timer:
  - Cleared on every rx_valid and held at 0 in IDLE.
  - Otherwise increments by 1 each cycle.
  - When it reaches TIMEOUT_CYCLES-1 with rx_valid low, the next edge forces IDLE and performs the error action with code 11.
- Simultaneous events: rx_valid in the timeout cycle wins. The byte is processed, the timer is cleared and no timeout occurs.

## Timing
- Reset values, applied asynchronously: state IDLE, CH_CONFIG_WE 0, CH_CONFIG_ADDR 0x00, CH_CONFIG_DATA 0x00, busy 0, frame_err 0, err_code 00, err_cnt 0, timer 0.
- All outputs are registered.
- WE latency: CH_CONFIG_WE is high in the cycle immediately after the rx_valid cycle that carries CHK. ADDR and DATA update on that same edge.
- frame_err has the same one-cycle latency as CH_CONFIG_WE.
- Back-to-back frames: a SYNC byte in the cycle right after CHK is accepted. The peak rate is one write per 5 cycles.
- busy rises on the edge after SYNC is received. It falls on the edge after CHK is received or on the timeout edge.
- Timeout edge: frame_err rises exactly TIMEOUT_CYCLES cycles after the last rx_valid of the partial frame.
- Reset asserted mid-frame: the partial frame is discarded with no WE and no error count. After reset_n deasserts, the next 0xA5 starts a fresh frame.

## Test plan
- Good unicast frame A5 00 2D 01 2C → one cycle with WE=01, ADDR=0x2D, DATA=0x01; frame_err stays 0.
- Broadcast frame A5 FF 31 05 CB → WE=11 for one cycle, ADDR=0x31, DATA=0x05. Repeat back-to-back with no gap → two WE pulses 5 cycles apart.
- Bad checksum A5 00 05 10 00 (expected CHK 0x15) → frame_err pulse, err_code=01, err_cnt=1, WE stays 0, ADDR/DATA unchanged.
- Bad channel A5 02 01 7F 7C with correct CHK and NUM_CH=2 → err_code=10, err_cnt increments, no WE.
- Stall A5 00, then idle → frame_err TIMEOUT_CYCLES cycles after the 0x00 byte, err_code=11, busy=0. A following good frame is accepted. A separate run presents a byte exactly in the timeout cycle → no timeout.
- Garbage 12 34 A5 00 2D 01 2C → exactly one write and no error. Sending 300 bad frames → err_cnt saturates at 255. Asserting reset_n after A5 00 2D → all outputs return to reset values, then a good frame is accepted normally.
